// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states, ACK levels, counter width.
package i2c_pkg;
  localparam int CNT_W = 4;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } state_t;
endpackage

// File: rtl/i2c_target_if.sv
// Register access port between the I2C target and the user register file.
interface i2c_target_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser plus history flop; level and edge pulses from the
// synchronised value only.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;

  // sr[1:0] synchronise, sr[2] is history; idle bus reads high
  always_ff @(posedge clk) begin
    if (rst) sr <= 3'b111;
    else     sr <= {sr[1:0], din};
  end

  assign lvl  = sr[1];
  assign rise =  sr[1] & ~sr[2];
  assign fall = ~sr[1] &  sr[2];
endmodule

// File: rtl/i2c_target.sv
// I2C target with byte-register access: pointer byte after a write address,
// auto-incrementing writes and reads, open-drain SDA, no clock stretching.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scl_i,
  input  logic         sda_i,
  output logic         sda_oe,
  output logic         busy,
  i2c_target_if.master rbus
);
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;

  i2c_sync_edge u_scl (.clk(clk), .rst(rst), .din(scl_i),
                       .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .rst(rst), .din(sda_i),
                       .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  assign start = scl_lvl & sda_fall;
  assign stop  = scl_lvl & sda_rise;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;     // SCL rises seen in the current 9-clock frame
  logic [7:0]       sh, sh_n;
  logic [7:0]       ptr, ptr_n;
  logic             oe_n, busy_n;
  logic             wen_n;
  logic [7:0]       waddr_n, wdata_n;
  logic [7:0]       byte_in;

  assign byte_in      = {sh[6:0], sda_lvl};
  assign rbus.rd_addr = ptr;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      sh           <= '0;
      ptr          <= '0;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      rbus.wr_en   <= 1'b0;
      rbus.wr_addr <= '0;
      rbus.wr_data <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sh           <= sh_n;
      ptr          <= ptr_n;
      sda_oe       <= oe_n;
      busy         <= busy_n;
      rbus.wr_en   <= wen_n;
      rbus.wr_addr <= waddr_n;
      rbus.wr_data <= wdata_n;
    end
  end

  // Next state and outputs; STOP beats START beats SCL bit events
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    ptr_n   = ptr;
    oe_n    = sda_oe;
    wen_n   = 1'b0;
    waddr_n = rbus.wr_addr;
    wdata_n = rbus.wr_data;

    if (stop) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else if (start) begin
      state_n = ST_ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            sh_n  = byte_in;
            cnt_n = cnt + 1'b1;
            if (cnt == CNT_W'(7))
              state_n = (byte_in[7:1] == TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
          end
        end

        ST_ADDR_ACK: begin
          // first fall starts the ACK, second fall ends it and turns the bus
          if (scl_rise) begin
            cnt_n = CNT_W'(9);
          end else if (scl_fall) begin
            if (cnt == CNT_W'(8)) begin
              oe_n = ~I2C_ACK;
            end else begin
              cnt_n = '0;
              if (sh[0]) begin
                state_n = ST_READ;
                sh_n    = rbus.rd_data;
                oe_n    = ~rbus.rd_data[7];
                ptr_n   = ptr + 8'd1;
              end else begin
                state_n = ST_PTR;
                oe_n    = 1'b0;
              end
            end
          end
        end

        ST_PTR, ST_WRITE: begin
          if (scl_rise) begin
            if (cnt < CNT_W'(8)) begin
              sh_n  = byte_in;
              cnt_n = cnt + 1'b1;
              if (cnt == CNT_W'(7)) begin
                if (state == ST_PTR) begin
                  ptr_n = byte_in;
                end else begin
                  wen_n   = 1'b1;
                  waddr_n = ptr;
                  wdata_n = byte_in;
                  ptr_n   = ptr + 8'd1;
                end
              end
            end else begin
              cnt_n = CNT_W'(9);
            end
          end else if (scl_fall) begin
            if (cnt == CNT_W'(8)) begin
              oe_n = ~I2C_ACK;
            end else if (cnt == CNT_W'(9)) begin
              oe_n    = 1'b0;
              cnt_n   = '0;
              state_n = ST_WRITE;
            end
          end
        end

        ST_READ: begin
          // first bit was already put on the bus when the byte was loaded
          if (scl_rise) begin
            if (cnt < CNT_W'(8))           cnt_n   = cnt + 1'b1;
            else if (sda_lvl == I2C_NACK) state_n = ST_IGNORE;
            else                          cnt_n   = CNT_W'(9);
          end else if (scl_fall) begin
            if (cnt != '0 && cnt < CNT_W'(8)) begin
              sh_n = {sh[6:0], 1'b0};
              oe_n = ~sh[6];
            end else if (cnt == CNT_W'(8)) begin
              oe_n = 1'b0;
            end else if (cnt == CNT_W'(9)) begin
              sh_n  = rbus.rd_data;
              oe_n  = ~rbus.rd_data[7];
              ptr_n = ptr + 8'd1;
              cnt_n = '0;
            end
          end
        end

        ST_IGNORE: oe_n = 1'b0;
        ST_IDLE:   oe_n = 1'b0;
        default:   state_n = ST_IDLE;
      endcase
    end

    busy_n = busy;
    if (state_n == ST_ADDR_ACK)                          busy_n = 1'b1;
    else if (state_n == ST_IDLE || state_n == ST_IGNORE) busy_n = 1'b0;
  end
endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) with a byte-register access model. It is the far end of the bus that `top_nes_bridge` drives as controller, so a second FPGA or the bench can answer `scl`/`sda` traffic. Bus events are decoded from oversampled SCL/SDA. Writes are presented as one-cycle register-write strobes, and read data is fetched from a user register port. There is no clock stretching, SCL is input-only, and the block drives SDA open-drain low only.

## Interface
Parameters:
- `TARGET_ADDR`, default 7'h42: 7-bit bus address the block answers.

Ports:
- `clk`  in  1  system clock; must be ≥ 16× SCL frequency.
- `rst`  in  1  synchronous, active-high reset.
- `scl_i`  in  1  raw SCL from the pad; asynchronous to `clk`.
- `sda_i`  in  1  raw SDA from the pad; asynchronous to `clk`.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `wr_en`  out  1  one-cycle register-write strobe.
- `wr_addr`  out  8  register index for `wr_en`.
- `wr_data`  out  8  write data for `wr_en`.
- `rd_addr`  out  8  current register pointer, always driven.
- `rd_data`  in  8  combinational read data for `rd_addr`.
- `busy`  out  1  high from an addressed START until STOP/NACK/mismatch.

## Operation
- **Input conditioning:** `scl_i` and `sda_i` each pass a 2-flop synchroniser plus a history flop. Rise, fall and level are derived from the synchronised values only.
- **START:** SDA falls while SCL is high. Valid in any state, including a repeated START. Clears the bit counter and goes to ADDR.
- **STOP:** SDA rises while SCL is high. Valid in any state; goes to IDLE with `sda_oe`=0.
- **Bit sampling:** on the SCL rise, MSB first.
- **SDA changes:** `sda_oe` changes only on a SCL fall.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If addr[7:1]==`TARGET_ADDR`, go to ADDR_ACK; otherwise go to IGNORE.
  - ADDR_ACK: drive ACK for the 9th clock. Then go to PTR if R/W=0. If R/W=1, go to READ, loading the shift register from `rd_data`.
  - PTR: the first byte after a write address becomes the pointer. ACK it; no `wr_en`.
  - WRITE: shift 8 bits, issue `wr_en` with `wr_addr`=pointer, ACK, then increment the pointer.
  - READ: drive shift-register bits (`sda_oe` = ~bit). On the 9th clock, release SDA and sample the controller ACK.
    - ACK (SDA=0): reload from `rd_data` and stay in READ.
    - NACK: go to IGNORE.
  - IGNORE: `sda_oe`=0; wait for STOP or START.
- **Pointer:** 8-bit and wraps 0xFF→0x00. It increments after each written byte and after each read byte is loaded. It persists across transactions and resets only on `rst`.
- **`busy`:** set on entry to ADDR_ACK. Cleared on IDLE or IGNORE.
- **Reset values:** `sda_oe`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, pointer/`rd_addr`=0, `busy`=0, state IDLE.
- **Reset mid-transfer:** SDA is released on the first clock of `rst`. Partial bytes are discarded.
- **Simultaneous STOP and any bit event:** STOP wins.
- **START/STOP mid-byte:** discard the partial byte with no `wr_en`.

## Timing
- **Synchroniser latency:** 2 `clk` cycles. Edges are detected in cycle 3 after the raw pad change.
- **`sda_oe` update:** registered. It changes 1 cycle after the detected SCL fall, i.e. 4 `clk` after the raw SCL fall. This must fall inside the SCL low phase, hence the ≥16× rule.
- **`wr_en`:** exactly one cycle, asserted the cycle after the 8th bit is sampled. `wr_addr`/`wr_data` are valid in the same cycle and held until the next strobe.
- **`rd_data` sampling:** sampled in the cycle of the SCL fall that ends ADDR_ACK or the controller's ACK. `rd_addr` has been stable for at least 1 cycle before that.
- **ACK bit:** `sda_oe`=1 from the SCL fall after bit 8 to the SCL fall after bit 9.

## Structure
- **Shared package `i2c_pkg`:** state encoding (IDLE, ADDR, ADDR_ACK, PTR, WRITE, READ, IGNORE), `I2C_ACK`=1'b0 and `I2C_NACK`=1'b1, and the bit-count width.
- **Sub-module `i2c_sync_edge`:** 2-flop synchroniser plus rise/fall/level outputs, instantiated for SCL and for SDA.
- **`i2c_target`:** holds the FSM, the 4-bit bit counter, the 8-bit shift register and the pointer.

## Test plan
- **Write burst:** START, 0x84, 0x10, 0xAB, 0xCD, STOP.
  - ACK (`sda_oe`=1) on all 4 ninth clocks.
  - `wr_en` pulses carry (0x10, 0xAB) and (0x11, 0xCD).
  - `rd_addr` ends at 0x12; `busy` is 0 after STOP.
- **Random read:** START, 0x84, 0x20, repeated START, 0x85, read 2 bytes (controller ACK, then NACK), STOP. The `rd_data` model is ~`rd_addr`.
  - Bytes seen on the bus: 0xDF, 0xDE.
  - Then IGNORE, no further SDA drive, `rd_addr`=0x22.
- **Address mismatch:** START, 0x86, 0x55, STOP.
  - `sda_oe` stays 0 throughout.
  - No `wr_en`; `busy` stays 0.
- **Pointer wrap:** START, 0x84, 0xFF, 0x11, 0x22, STOP.
  - `wr_en` carries (0xFF, 0x11) then (0x00, 0x22).
- **Aborted byte:** START, 0x84, 0x30, 4 data bits, STOP.
  - No third `wr_en`; state returns to IDLE.
  - The next transaction works normally.
- **Reset mid-read:** assert `rst` while `sda_oe`=1 in READ.
  - `sda_oe`=0 after the first `rst` clock.
  - All outputs are at their reset values; pointer is 0.
